// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding requests to a
// variable-latency instruction memory and holds each fetched word until decode accepts it.
module if_fetch_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = 32'h00000000,
  parameter logic [WIDTH-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] pc_if,
  output logic [WIDTH-1:0] instr_if,
  output logic             if_valid,
  output logic             fetch_busy
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] instr_buf;
  logic [WIDTH-1:0] instr_buf_nxt;
  logic [WIDTH-1:0] target_pc;

  // Redirect targets are word aligned; the low two bits are simply dropped.
  assign target_pc = redirect_pc & ~(WIDTH'(3));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      instr_buf <= NOP_INSTR;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      instr_buf <= instr_buf_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    instr_buf_nxt = instr_buf;
    if (redirect) begin
      pc_nxt = target_pc;
      unique case (state)
        S_REQ:   state_nxt = S_REQ;
        // A killed request still owes us a response; DRAIN swallows it.
        S_WAIT:  state_nxt = imem_rvalid ? S_REQ : S_DRAIN;
        S_HOLD:  state_nxt = S_REQ;
        S_DRAIN: state_nxt = imem_rvalid ? S_REQ : S_DRAIN;
        default: state_nxt = S_REQ;
      endcase
    end else begin
      unique case (state)
        S_REQ:   state_nxt = S_WAIT;
        S_WAIT: begin
          if (imem_rvalid) begin
            instr_buf_nxt = imem_rdata;
            state_nxt     = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            pc_nxt    = pc + WIDTH'(4);
            state_nxt = S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid) state_nxt = S_REQ;
        end
        default: state_nxt = S_REQ;
      endcase
    end
  end

  // Outputs decode from registered state; only imem_req also sees redirect and reset.
  assign imem_req   = (state == S_REQ) && !redirect && !rst;
  assign imem_addr  = pc;
  assign if_valid   = (state == S_HOLD);
  assign instr_if   = (state == S_HOLD) ? instr_buf : NOP_INSTR;
  assign pc_if      = pc;
  assign fetch_busy = (state != S_HOLD);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed timing scenarios plus a randomized run
// scored against a fetch-order model with a variable-latency memory.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pc_if;
  logic [31:0] instr_if;
  logic        if_valid;
  logic        fetch_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 1;

  if_fetch_unit #(.WIDTH(32), .RESET_PC(32'h00000000), .NOP_INSTR(32'h00000013)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .pc_if(pc_if), .instr_if(instr_if), .if_valid(if_valid),
    .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0F0F1234;
  endfunction

  // Instruction memory: answers each request after lat cycles (lat==0 -> random 1..4).
  int          cnt = 0;
  int          l;
  logic [31:0] paddr = 32'h0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= 0;
      imem_rvalid <= 1'b0;
      imem_rdata  <= 32'h0;
    end else begin
      imem_rvalid <= 1'b0;
      if (imem_req) begin
        l = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
        if (l == 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= mem_word(imem_addr);
        end else begin
          cnt   <= l - 1;
          paddr <= imem_addr;
        end
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= mem_word(paddr);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input int latency);
    lat = latency; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", imem_req); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", if_valid); end
    n_checks++; if (instr_if !== NOP) begin n_fail++; $display("FAIL reset_instr got %h exp %h", instr_if, NOP); end
    n_checks++; if (pc_if !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", pc_if); end
    n_checks++; if (fetch_busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b exp 1", fetch_busy); end
  endtask

  // 1-cycle memory stream, then a 5-cycle stall while holding pc 0x8.
  task automatic test_stream_stall;
    logic er, ev; logic [31:0] ea, ep;
    do_reset(1);
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      stall = (k >= 8 && k <= 12); redirect = 1'b0;
      @(negedge clk);
      er = (k == 0 || k == 3 || k == 6 || k == 14);
      ea = (k == 14) ? 32'hC : 32'(4 * (k / 3));
      ev = (k == 2 || k == 5 || (k >= 8 && k <= 13));
      ep = (k == 2) ? 32'h0 : (k == 5) ? 32'h4 : 32'h8;
      n_checks++; if (imem_req !== er) begin n_fail++; $display("FAIL stream_req k=%0d got %b exp %b", k, imem_req, er); end
      if (er) begin
        n_checks++; if (imem_addr !== ea) begin n_fail++; $display("FAIL stream_addr k=%0d got %h exp %h", k, imem_addr, ea); end
      end
      n_checks++; if (if_valid !== ev) begin n_fail++; $display("FAIL stream_valid k=%0d got %b exp %b", k, if_valid, ev); end
      if (ev) begin
        n_checks++; if (pc_if !== ep) begin n_fail++; $display("FAIL stream_pc k=%0d got %h exp %h", k, pc_if, ep); end
        n_checks++; if (instr_if !== mem_word(ep)) begin n_fail++; $display("FAIL stream_instr k=%0d got %h exp %h", k, instr_if, mem_word(ep)); end
      end else begin
        n_checks++; if (instr_if !== NOP) begin n_fail++; $display("FAIL stream_nop k=%0d got %h exp %h", k, instr_if, NOP); end
      end
    end
  endtask

  // 4-cycle memory; redirect to 0x100 one cycle after the request at 0x4.
  task automatic test_latency_redirect;
    logic er, ev; logic [31:0] ea, ep;
    do_reset(4);
    for (int c = 0; c <= 17; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      redirect = (c == 7); redirect_pc = 32'h100; stall = 1'b0;
      @(negedge clk);
      er = (c == 0 || c == 6 || c == 11 || c == 17);
      ea = (c == 0) ? 32'h0 : (c == 6) ? 32'h4 : (c == 11) ? 32'h100 : 32'h104;
      ev = (c == 5 || c == 16);
      ep = (c == 5) ? 32'h0 : 32'h100;
      n_checks++; if (imem_req !== er) begin n_fail++; $display("FAIL lat_req c=%0d got %b exp %b", c, imem_req, er); end
      if (er) begin
        n_checks++; if (imem_addr !== ea) begin n_fail++; $display("FAIL lat_addr c=%0d got %h exp %h", c, imem_addr, ea); end
      end
      n_checks++; if (if_valid !== ev) begin n_fail++; $display("FAIL lat_valid c=%0d got %b exp %b", c, if_valid, ev); end
      if (ev) begin
        n_checks++; if (pc_if !== ep) begin n_fail++; $display("FAIL lat_pc c=%0d got %h exp %h", c, pc_if, ep); end
        n_checks++; if (instr_if !== mem_word(ep)) begin n_fail++; $display("FAIL lat_instr c=%0d got %h exp %h", c, instr_if, mem_word(ep)); end
      end
    end
  endtask

  // Redirect to 0x203 in the same WAIT cycle as the response.
  task automatic test_redirect_with_rvalid;
    do_reset(1);
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      redirect = (c == 1); redirect_pc = 32'h203; stall = 1'b0;
      @(negedge clk);
      if (c == 1) begin
        n_checks++; if (imem_rvalid !== 1'b1) begin n_fail++; $display("FAIL rv_setup got %b exp 1", imem_rvalid); end
      end
      if (c == 2) begin
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rv_req got %b exp 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h200) begin n_fail++; $display("FAIL rv_addr got %h exp 00000200", imem_addr); end
      end
      n_checks++; if (if_valid !== (c == 4)) begin n_fail++; $display("FAIL rv_valid c=%0d got %b exp %b", c, if_valid, (c == 4)); end
      if (c == 4) begin
        n_checks++; if (instr_if !== mem_word(32'h200)) begin n_fail++; $display("FAIL rv_instr got %h exp %h", instr_if, mem_word(32'h200)); end
      end
    end
  endtask

  // Redirect to 0x40 while holding pc 0x20 under stall.
  task automatic test_redirect_hold;
    logic er; logic [31:0] ea;
    do_reset(1);
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      stall = (c >= 3); redirect = (c == 0 || c == 4);
      redirect_pc = (c == 0) ? 32'h20 : 32'h40;
      @(negedge clk);
      er = (c == 1 || c == 5);
      ea = (c == 1) ? 32'h20 : 32'h40;
      n_checks++; if (imem_req !== er) begin n_fail++; $display("FAIL hold_req c=%0d got %b exp %b", c, imem_req, er); end
      if (er) begin
        n_checks++; if (imem_addr !== ea) begin n_fail++; $display("FAIL hold_addr c=%0d got %h exp %h", c, imem_addr, ea); end
      end
      n_checks++; if (if_valid !== (c == 3 || c == 4)) begin n_fail++; $display("FAIL hold_valid c=%0d got %b", c, if_valid); end
      if (c == 4) begin
        n_checks++; if (pc_if !== 32'h20) begin n_fail++; $display("FAIL hold_pc got %h exp 00000020", pc_if); end
      end
    end
    stall = 1'b0;
  endtask

  // PC wrap from 0xFFFFFFFC, then asynchronous reset in the middle of WAIT.
  task automatic test_wrap_async_reset;
    logic er; logic [31:0] ea;
    do_reset(3);
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      redirect = (c == 0); redirect_pc = 32'hFFFFFFFC; stall = 1'b0;
      @(negedge clk);
      er = (c == 1 || c == 6);
      ea = (c == 1) ? 32'hFFFFFFFC : 32'h0;
      n_checks++; if (imem_req !== er) begin n_fail++; $display("FAIL wrap_req c=%0d got %b exp %b", c, imem_req, er); end
      if (er) begin
        n_checks++; if (imem_addr !== ea) begin n_fail++; $display("FAIL wrap_addr c=%0d got %h exp %h", c, imem_addr, ea); end
      end
      if (c == 5) begin
        n_checks++; if (if_valid !== 1'b1 || pc_if !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wrap_hold got v=%b pc=%h exp v=1 pc=fffffffc", if_valid, pc_if); end
      end
    end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL arst_req got %b exp 0", imem_req); end
    n_checks++; if (fetch_busy !== 1'b1 || if_valid !== 1'b0) begin n_fail++; $display("FAIL arst_state got busy=%b v=%b exp busy=1 v=0", fetch_busy, if_valid); end
    n_checks++; if (instr_if !== NOP || pc_if !== 32'h0) begin n_fail++; $display("FAIL arst_out got %h/%h exp 00000013/00000000", instr_if, pc_if); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL arst_release got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
  endtask

  // Random stall/redirect/latency; the model only knows which PC must come next.
  task automatic test_random;
    logic [31:0] exp_pc;
    bit          outstanding;
    int          delivered;
    exp_pc = 32'h0; outstanding = 1'b0; delivered = 0;
    do_reset(0);
    for (int c = 0; c < 1500; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      stall       = ($urandom_range(0, 99) < 30);
      redirect    = ($urandom_range(0, 99) < 4);
      redirect_pc = $urandom & 32'h0003FFFF;
      @(negedge clk);
      n_checks++; if (fetch_busy !== !if_valid) begin n_fail++; $display("FAIL rnd_busy c=%0d got %b exp %b", c, fetch_busy, !if_valid); end
      if (imem_rvalid) outstanding = 1'b0;
      if (imem_req) begin
        n_checks++; if (imem_addr !== exp_pc) begin n_fail++; $display("FAIL rnd_addr c=%0d got %h exp %h", c, imem_addr, exp_pc); end
        n_checks++; if (outstanding) begin n_fail++; $display("FAIL rnd_outstanding c=%0d got 2 requests exp 1", c); end
        outstanding = 1'b1;
      end
      if (if_valid) begin
        n_checks++; if (pc_if !== exp_pc) begin n_fail++; $display("FAIL rnd_pc c=%0d got %h exp %h", c, pc_if, exp_pc); end
        n_checks++; if (instr_if !== mem_word(exp_pc)) begin n_fail++; $display("FAIL rnd_instr c=%0d got %h exp %h", c, instr_if, mem_word(exp_pc)); end
      end else begin
        n_checks++; if (instr_if !== NOP) begin n_fail++; $display("FAIL rnd_nop c=%0d got %h exp %h", c, instr_if, NOP); end
      end
      if (redirect) exp_pc = redirect_pc & 32'hFFFFFFFC;
      else if (if_valid && !stall) begin
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
    end
    n_checks++; if (delivered < 50) begin n_fail++; $display("FAIL rnd_progress got %0d deliveries exp >= 50", delivered); end
    redirect = 1'b0; stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream_stall();
    test_latency_redirect();
    test_redirect_with_rvalid();
    test_redirect_hold();
    test_wrap_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
